// File: rtl/free_addr_pool.sv
// rtl/free_addr_pool.sv - free buffer-address pool with round-robin return and allocate channels
module free_addr_pool #(
    parameter int NUM_CH     = 4,
    parameter int ADDR_W     = 12,
    parameter int POOL_DEPTH = 4096,
    parameter int LOW_WM     = 8,
    localparam int CNT_W     = $clog2(POOL_DEPTH + 1)
) (
    input  logic                     iClk,
    input  logic                     iRst_n,
    input  logic [NUM_CH*ADDR_W-1:0] iRetAddr,
    input  logic [NUM_CH-1:0]        iRetVld,
    output logic [NUM_CH-1:0]        oRetRdy,
    input  logic [ADDR_W-1:0]        iDropAddr,
    input  logic                     iDropVld,
    output logic [NUM_CH*ADDR_W-1:0] oAllocAddr,
    output logic [NUM_CH-1:0]        oAllocVld,
    input  logic [NUM_CH-1:0]        iAllocRdy,
    output logic [CNT_W-1:0]         oFreeCnt,
    output logic                     oEmpty,
    output logic                     oLowWater,
    output logic                     oInitDone,
    output logic                     oErrOvf
);

    localparam int PTR_W = (POOL_DEPTH > 1) ? $clog2(POOL_DEPTH) : 1;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(POOL_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(POOL_DEPTH);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                    state_q;
    logic [ADDR_W-1:0]         mem_q [POOL_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q;
    logic [PTR_W-1:0]          rd_ptr_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [CH_W-1:0]           rr_ret_q;
    logic [CH_W-1:0]           rr_alloc_q;
    logic [NUM_CH-1:0]         alloc_vld_q;
    logic [NUM_CH*ADDR_W-1:0]  alloc_addr_q;
    logic                      init_done_q;
    logic                      err_ovf_q;

    logic                      run;
    logic                      full;
    logic                      ret_gnt_vld;
    logic [CH_W-1:0]           ret_gnt_idx;
    logic                      alloc_gnt_vld;
    logic [CH_W-1:0]           alloc_gnt_idx;
    logic                      ret_en;
    logic                      drop_ok;
    logic                      drop_err;
    logic                      rd_en;
    logic                      wr_en;
    logic                      run_wr;
    logic [ADDR_W-1:0]         wr_data;
    logic [ADDR_W-1:0]         rd_data;
    logic [NUM_CH-1:0]         take;
    logic [NUM_CH-1:0]         alloc_set;

    // Channel visited at position off of a round-robin scan that starts at base.
    function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_CH) s = s - NUM_CH;
        return CH_W'(s);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [CH_W-1:0] ch_inc(input logic [CH_W-1:0] c);
        return (c == CH_LAST) ? '0 : c + CH_W'(1);
    endfunction

    assign run  = (state_q == S_RUN);
    assign full = (cnt_q == CNT_FULL);

    // Round-robin pick of the returning channel and of the empty output slot to refill.
    always_comb begin
        ret_gnt_vld   = 1'b0;
        ret_gnt_idx   = '0;
        alloc_gnt_vld = 1'b0;
        alloc_gnt_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!ret_gnt_vld && iRetVld[rr_idx(rr_ret_q, i)]) begin
                ret_gnt_vld = 1'b1;
                ret_gnt_idx = rr_idx(rr_ret_q, i);
            end
            if (!alloc_gnt_vld && !alloc_vld_q[rr_idx(rr_alloc_q, i)]) begin
                alloc_gnt_vld = 1'b1;
                alloc_gnt_idx = rr_idx(rr_alloc_q, i);
            end
        end
    end

    // Drop owns the single write port; a return only wins when no drop and space remains.
    always_comb begin
        drop_ok   = run && iDropVld && !full;
        drop_err  = iDropVld && (!run || full);
        ret_en    = run && !iDropVld && !full && ret_gnt_vld;
        run_wr    = drop_ok || ret_en;
        wr_en     = !run || run_wr;
        rd_en     = run && (cnt_q != '0) && alloc_gnt_vld;
        take      = alloc_vld_q & iAllocRdy;
        alloc_set = rd_en ? (NUM_CH'(1) << alloc_gnt_idx) : '0;
        if (!run) begin
            wr_data = ADDR_W'(wr_ptr_q);
        end else if (iDropVld) begin
            wr_data = iDropAddr;
        end else begin
            wr_data = iRetAddr[int'(ret_gnt_idx)*ADDR_W +: ADDR_W];
        end
        rd_data = mem_q[rd_ptr_q];
    end

    // Address storage; contents are rebuilt by INIT after every reset, so no reset here.
    always_ff @(posedge iClk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end

    // Control FSM: INIT fills the pool with 0..POOL_DEPTH-1, RUN serves returns and allocations.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q      <= S_INIT;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            rr_ret_q     <= '0;
            rr_alloc_q   <= '0;
            alloc_vld_q  <= '0;
            alloc_addr_q <= '0;
            init_done_q  <= 1'b0;
            err_ovf_q    <= 1'b0;
        end else begin
            if (drop_err) err_ovf_q <= 1'b1;
            case (state_q)
                S_INIT: begin
                    wr_ptr_q <= ptr_inc(wr_ptr_q);
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (wr_ptr_q == PTR_LAST) begin
                        state_q     <= S_RUN;
                        init_done_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    alloc_vld_q <= (alloc_vld_q & ~take) | alloc_set;
                    if (rd_en) begin
                        alloc_addr_q[int'(alloc_gnt_idx)*ADDR_W +: ADDR_W] <= rd_data;
                        rd_ptr_q   <= ptr_inc(rd_ptr_q);
                        rr_alloc_q <= ch_inc(alloc_gnt_idx);
                    end
                    if (run_wr) wr_ptr_q <= ptr_inc(wr_ptr_q);
                    if (ret_en) rr_ret_q <= ch_inc(ret_gnt_idx);
                    if (run_wr && !rd_en) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end else if (!run_wr && rd_en) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= S_INIT;
            endcase
        end
    end

    assign oRetRdy    = ret_en ? (NUM_CH'(1) << ret_gnt_idx) : '0;
    assign oAllocVld  = alloc_vld_q;
    assign oAllocAddr = alloc_addr_q;
    assign oFreeCnt   = cnt_q;
    assign oEmpty     = (cnt_q == '0);
    assign oLowWater  = (int'(cnt_q) <= LOW_WM);
    assign oInitDone  = init_done_q;
    assign oErrOvf    = err_ovf_q;

endmodule
